cpu_sram_bridge: RTL



---
 rtl/cpu_sram_bridge_pkg.sv | 17 +
 rtl/cpu_sram_size_dec.sv | 28 ++
 rtl/cpu_sram_bridge.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cpu_sram_bridge_pkg.sv
// Shared definitions for the CPU SRAM-to-handshake bridge: FSM encoding,
// transfer size codes and byte-strobe width.
package cpu_sram_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam int STRB_W = 4;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/cpu_sram_size_dec.sv
// Byte-enable decoder: maps core write enables to bus direction, transfer
// size and an illegal-pattern flag. Purely combinational.
module cpu_sram_size_dec
    import cpu_sram_bridge_pkg::*;
(
    input  logic [STRB_W-1:0] we,
    output logic              wr,
    output logic [1:0]        size,
    output logic              illegal
);

    // Non-contiguous or 3-byte patterns fall back to a word access and are flagged.
    always_comb begin
        wr      = |we;
        size    = SIZE_W;
        illegal = 1'b0;
        case (we)
            4'b0000, 4'b1111:                   size = SIZE_W;
            4'b0011, 4'b1100:                   size = SIZE_H;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_B;
            default: begin
                size    = SIZE_W;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cpu_sram_bridge.sv
// Converts one-cycle SRAM-style core accesses into a req/addr_ok/data_ok
// split transaction, stalling the core until each access completes.
module cpu_sram_bridge
    import cpu_sram_bridge_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_en,
    input  logic [STRB_W-1:0] cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_strb,
    output logic              err_timeout
);

    localparam int              CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    state_t              state_r;
    logic [STRB_W-1:0]   we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_inc_s;
    logic [STRB_W-1:0]   we_s;
    logic                illegal_s;

    cpu_sram_size_dec u_size_dec (
        .we      (we_s),
        .wr      (mem_wr),
        .size    (mem_size),
        .illegal (illegal_s)
    );

    assign mem_wstrb = we_s;
    assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);

    // In IDLE the request is a combinational pass-through; afterwards the captured payload is replayed.
    always_comb begin
        mem_req   = 1'b0;
        cpu_stall = 1'b0;
        we_s      = we_r;
        mem_addr  = addr_r;
        mem_wdata = wdata_r;
        case (state_r)
            ST_IDLE: begin
                mem_req   = cpu_en;
                cpu_stall = cpu_en;
                we_s      = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            ST_REQ: begin
                mem_req   = 1'b1;
                cpu_stall = 1'b1;
            end
            ST_WAIT: begin
                mem_req   = 1'b0;
                cpu_stall = ~mem_data_ok;
            end
            default: begin
                mem_req   = 1'b0;
                cpu_stall = 1'b0;
            end
        endcase
    end

    // Transaction FSM, payload capture, latency counter and sticky error flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            we_r        <= '0;
            addr_r      <= '0;
            wdata_r     <= '0;
            cnt_r       <= '0;
            cpu_rdata   <= '0;
            err_strb    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (mem_req && illegal_s) begin
                err_strb <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    if (cpu_en) begin
                        we_r    <= cpu_we;
                        addr_r  <= cpu_addr;
                        wdata_r <= cpu_wdata;
                        state_r <= mem_addr_ok ? ST_WAIT : ST_REQ;
                    end
                end
                ST_REQ: begin
                    cnt_r <= cnt_inc_s;
                    if (cnt_inc_s == CNT_MAX) begin
                        err_timeout <= 1'b1;
                    end
                    if (mem_addr_ok) begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_inc_s;
                    if (mem_data_ok) begin
                        if (!mem_wr) begin
                            cpu_rdata <= mem_rdata;
                        end
                        state_r <= ST_IDLE;
                    end else if (cnt_inc_s == CNT_MAX) begin
                        err_timeout <= 1'b1;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule
